uart_code_lock_ctrl: RTL
========================

Name: uart_code_lock_ctrl

Overview:
- Command sequencer between the UART receiver byte stream (rx_valid/rx_byte) and the lock actuator.
- Replaces single-character open/close with a PIN entry: ASCII digits, then '#'.
- Adds timed auto-relock, failed-attempt counting and a timed lockout.
- Optionally returns a status byte to a UART transmitter.

Parameters:
- CODE, 32'h31323334, expected PIN as 4 ASCII digits, MSB first ("1234").
- OPEN_CYCLES, 250000000, clk cycles lock stays open (5 s at 50 MHz); must be >= 1.
- MAX_FAILS, 3, consecutive wrong entries that trigger lockout; 1..7.
- LOCKOUT_CYCLES, 1500000000, clk cycles all input is ignored after MAX_FAILS; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- tx_busy  in  1  UART transmitter busy
- lock_open  out  1  1 = lock released
- lockout  out  1  1 = lockout active
- fail_count  out  3  consecutive wrong entries
- state_dbg  out  3  current FSM state encoding
- tx_start  out  1  one-cycle transmit request
- tx_byte  out  8  byte to transmit

Behaviour:
- Single clock domain, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, lock_open 0, lockout 0, fail_count 0, tx_start 0, tx_byte 8'h00. Entry register, digit count and timer are cleared.
- Reset asserted mid-operation (open, lockout, entry) aborts immediately to these values.
- Entry storage: 32-bit shift register; each digit is shifted in at the LSB byte. 3-bit digit count saturates at 5; count 5 means overlength.
- FSM states and encodings: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4.
- IDLE/ENTRY, byte handling on rx_valid:
  - '0'..'9' (0x30-0x39): shift in, increment count, go to ENTRY.
  - '#' (0x23): go to CHECK.
  - '*' (0x2A) or 'C' (0x43): clear entry, go to IDLE.
  - All other bytes: ignored.
- CHECK (exactly one cycle; any rx_valid in this cycle is dropped):
  - Match when count==4 and entry==CODE: go to OPEN, load timer with OPEN_CYCLES-1, fail_count <= 0.
  - Otherwise fail_count+1. If the new value == MAX_FAILS: go to LOCKOUT, load timer with LOCKOUT_CYCLES-1. Else go to IDLE.
  - Entry is cleared on exit in all cases.
  - '#' with zero digits counts as a wrong entry.
- OPEN:
  - lock_open=1, registered. It rises on the clk edge that enters OPEN: 2 cycles after the cycle in which '#' was accepted.
  - Timer decrements each cycle. At 0: go to IDLE, lock_open 0.
  - rx 'C': go to IDLE, lock_open 0, on the next edge.
  - 'C' arriving on the same cycle the timer hits 0: single transition to IDLE, one close event only.
  - All other bytes (digits, '#', '*') are ignored. A new entry is only possible after close.
- LOCKOUT:
  - lockout=1, lock_open=0, every rx byte ignored.
  - Timer decrements; at 0: go to IDLE, lockout 0, fail_count 0.
- fail_count saturates at MAX_FAILS and is visible during LOCKOUT.
- Timer is a 32-bit down-counter. No wrap-around: it is reloaded only on state entry.
- Illegal state encodings recover to IDLE with all outputs at reset values.

Optional Feature:
- Macro: UART_LOCK_ACK_EN.
- Defined: on each event, queue an ack byte.
  - 'O' (0x4F): entering OPEN.
  - 'E' (0x45): wrong entry without lockout.
  - 'L' (0x4C): entering LOCKOUT.
  - 'K' (0x4B): OPEN to IDLE, by 'C' or by timeout.
- Ack transmit rules:
  - One-entry pending buffer.
  - When pending and tx_busy==0: tx_byte is set and tx_start pulses high for exactly one cycle, and pending clears.
  - While tx_busy==1 the byte is held.
  - A new event while pending overwrites the byte (latest status wins).
  - Earliest tx_start is 1 cycle after the state entry.
- Undefined: tx_start constant 0, tx_byte constant 8'h00, tx_busy unused; no pending logic is synthesized.

Test Plan (bench parameters OPEN_CYCLES=100, LOCKOUT_CYCLES=200, MAX_FAILS=3):
- "1234#" -> lock_open 1 two cycles after '#' strobe, held 100 cycles, then 0; fail_count 0.
- "1234#" then 'C' at open cycle 10 -> lock_open 0 next edge; state_dbg 0. 'C' injected on the timer-expiry cycle -> single close, ('K' once with ack).
- "1239#", "12#", "12345#" -> fail_count 1,2,3; lockout 1 after the third. "1234#" during lockout -> ignored, lock_open stays 0. After 200 cycles lockout 0, fail_count 0.
- "12*34#" -> wrong (count 2), fail_count 1. Then "1234#" -> opens, fail_count 0. Non-digit 'x' mid-entry is ignored: "12x34#" opens.
- rst pulse while OPEN and while LOCKOUT -> all outputs 0 asynchronously. The next "1234#" opens normally.
- With UART_LOCK_ACK_EN and tx_busy held 1 for 50 cycles after "1234#": tx_start stays 0. One-cycle tx_start with tx_byte 0x4F after tx_busy falls.

Source files
------------

// File: rtl/uart_code_lock_ctrl.sv
// uart_code_lock_ctrl
// Sequencer between a UART receive byte stream and a lock actuator.
// A PIN is typed as ASCII digits and confirmed with '#'. A correct PIN opens the
// lock for OPEN_CYCLES clocks. MAX_FAILS consecutive wrong PINs start a lockout
// of LOCKOUT_CYCLES clocks, and all input is ignored while it runs.
// Optional feature: define UART_LOCK_ACK_EN to send a one-byte status ('O', 'E',
// 'L', 'K') to a UART transmitter through a one-entry pending buffer.
module uart_code_lock_ctrl #(
  parameter logic [31:0] CODE           = 32'h31323334,
  parameter int unsigned OPEN_CYCLES    = 250000000,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       tx_busy,
  output logic       lock_open,
  output logic       lockout,
  output logic [2:0] fail_count,
  output logic [2:0] state_dbg,
  output logic       tx_start,
  output logic [7:0] tx_byte
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_OPEN    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_STAR = 8'h2A;
  localparam logic [7:0] CH_C    = 8'h43;

  localparam logic [7:0] ACK_OPEN  = 8'h4F;
  localparam logic [7:0] ACK_ERR   = 8'h45;
  localparam logic [7:0] ACK_LOCK  = 8'h4C;
  localparam logic [7:0] ACK_CLOSE = 8'h4B;

  // The timers count down to zero, so the reload value is the duration minus one.
  localparam logic [31:0] OPEN_RELOAD = 32'(OPEN_CYCLES - 32'd1);
  localparam logic [31:0] LOCK_RELOAD = 32'(LOCKOUT_CYCLES - 32'd1);
  localparam logic [2:0]  FAIL_LIMIT  = 3'(MAX_FAILS);

  // Count value that marks an overlength entry; digits beyond it no longer count.
  localparam logic [2:0]  COUNT_SAT   = 3'd5;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  logic [2:0]  state_r;
  logic [31:0] entry_r;
  logic [2:0]  count_r;
  logic [31:0] timer_r;
  logic [2:0]  fail_r;
  logic        lock_open_r;
  logic        lockout_r;

  logic [2:0]  state_nxt_s;
  logic [31:0] entry_nxt_s;
  logic [2:0]  count_nxt_s;
  logic [31:0] timer_nxt_s;
  logic [2:0]  fail_nxt_s;
  logic [2:0]  fail_inc_s;
  logic        evt_valid_s;
  logic [7:0]  evt_byte_s;
  logic        illegal_s;

  // Next-state, entry, timer and fail-count decisions for the command sequencer.
  always_comb begin
    state_nxt_s = state_r;
    entry_nxt_s = entry_r;
    count_nxt_s = count_r;
    timer_nxt_s = timer_r;
    fail_nxt_s  = fail_r;
    fail_inc_s  = fail_r + 3'd1;
    evt_valid_s = 1'b0;
    evt_byte_s  = 8'h00;
    illegal_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_ENTRY: begin
        if (rx_valid) begin
          if (is_digit(rx_byte)) begin
            entry_nxt_s = {entry_r[23:0], rx_byte};
            if (count_r >= COUNT_SAT) begin
              count_nxt_s = COUNT_SAT;
            end else begin
              count_nxt_s = count_r + 3'd1;
            end
            state_nxt_s = ST_ENTRY;
          end else if (rx_byte == CH_HASH) begin
            state_nxt_s = ST_CHECK;
          end else if ((rx_byte == CH_STAR) || (rx_byte == CH_C)) begin
            entry_nxt_s = 32'h0000_0000;
            count_nxt_s = 3'd0;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CHECK: begin
        // Input arriving in this cycle is dropped; the entry is always consumed.
        entry_nxt_s = 32'h0000_0000;
        count_nxt_s = 3'd0;
        evt_valid_s = 1'b1;
        if ((count_r == 3'd4) && (entry_r == CODE)) begin
          state_nxt_s = ST_OPEN;
          timer_nxt_s = OPEN_RELOAD;
          fail_nxt_s  = 3'd0;
          evt_byte_s  = ACK_OPEN;
        end else if (fail_inc_s >= FAIL_LIMIT) begin
          state_nxt_s = ST_LOCKOUT;
          timer_nxt_s = LOCK_RELOAD;
          fail_nxt_s  = FAIL_LIMIT;
          evt_byte_s  = ACK_LOCK;
        end else begin
          state_nxt_s = ST_IDLE;
          fail_nxt_s  = fail_inc_s;
          evt_byte_s  = ACK_ERR;
        end
      end
      ST_OPEN: begin
        // Timeout and a manual 'C' in the same cycle merge into one close.
        if ((timer_r == 32'd0) || (rx_valid && (rx_byte == CH_C))) begin
          state_nxt_s = ST_IDLE;
          evt_valid_s = 1'b1;
          evt_byte_s  = ACK_CLOSE;
        end else begin
          timer_nxt_s = timer_r - 32'd1;
        end
      end
      ST_LOCKOUT: begin
        if (timer_r == 32'd0) begin
          state_nxt_s = ST_IDLE;
          fail_nxt_s  = 3'd0;
        end else begin
          timer_nxt_s = timer_r - 32'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        entry_nxt_s = 32'h0000_0000;
        count_nxt_s = 3'd0;
        timer_nxt_s = 32'd0;
        fail_nxt_s  = 3'd0;
        illegal_s   = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered lock outputs, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      entry_r     <= 32'h0000_0000;
      count_r     <= 3'd0;
      timer_r     <= 32'd0;
      fail_r      <= 3'd0;
      lock_open_r <= 1'b0;
      lockout_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      entry_r     <= entry_nxt_s;
      count_r     <= count_nxt_s;
      timer_r     <= timer_nxt_s;
      fail_r      <= fail_nxt_s;
      lock_open_r <= (state_nxt_s == ST_OPEN);
      lockout_r   <= (state_nxt_s == ST_LOCKOUT);
    end
  end

  assign lock_open  = lock_open_r;
  assign lockout    = lockout_r;
  assign fail_count = fail_r;
  assign state_dbg  = state_r;

`ifdef UART_LOCK_ACK_EN
  logic       pend_r;
  logic [7:0] pend_byte_r;
  logic       tx_start_r;
  logic [7:0] tx_byte_r;
  logic       issue_s;

  assign issue_s = pend_r && !tx_busy;

  // One-entry status buffer: the newest event overwrites, an idle transmitter drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r      <= 1'b0;
      pend_byte_r <= 8'h00;
      tx_start_r  <= 1'b0;
      tx_byte_r   <= 8'h00;
    end else if (illegal_s) begin
      pend_r      <= 1'b0;
      pend_byte_r <= 8'h00;
      tx_start_r  <= 1'b0;
      tx_byte_r   <= 8'h00;
    end else begin
      if (issue_s) begin
        tx_start_r <= 1'b1;
        tx_byte_r  <= pend_byte_r;
      end else begin
        tx_start_r <= 1'b0;
        tx_byte_r  <= tx_byte_r;
      end
      if (evt_valid_s) begin
        pend_r      <= 1'b1;
        pend_byte_r <= evt_byte_s;
      end else if (issue_s) begin
        pend_r      <= 1'b0;
        pend_byte_r <= pend_byte_r;
      end else begin
        pend_r      <= pend_r;
        pend_byte_r <= pend_byte_r;
      end
    end
  end

  assign tx_start = tx_start_r;
  assign tx_byte  = tx_byte_r;
`else
  // Without the status channel the transmitter interface is tied off.
  logic unused_ack_inputs;
  assign unused_ack_inputs = ^{tx_busy, evt_valid_s, evt_byte_s, illegal_s};
  assign tx_start = 1'b0;
  assign tx_byte  = 8'h00;
`endif

endmodule
